// File: rtl/cl_uart_pkg.sv
// Shared types and defaults for the CameraLink UART serial PHY.
package cl_uart_pkg;

  localparam int unsigned CL_UART_DEFAULT_BAUD = 9_600;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } cl_uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } cl_uart_rx_state_t;

endpackage

// File: rtl/cl_uart_tx_fifo.sv
// Show-ahead synchronous byte FIFO; a push on full is accepted only when a pop frees a slot in the same cycle.
module cl_uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cameralink_uart_phy.sv
// CameraLink UART serial end: FIFO-buffered 8N1 transmitter on SerTC and 8N1 receiver on SerTFG.
module cameralink_uart_phy
  import cl_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned BAUD_RATE     = CL_UART_DEFAULT_BAUD,
  parameter int unsigned TX_FIFO_DEPTH = 16
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_areset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_frame_err,
  output logic       cl_sertc,
  input  logic       cl_sertfg
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned FIFO_CW      = $clog2(TX_FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  cl_uart_tx_state_t  tx_state;
  logic [CNT_W-1:0]   tx_cnt;
  logic [2:0]         tx_bit;
  logic [7:0]         tx_shift;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [7:0]         fifo_dout;
  logic [FIFO_CW-1:0] fifo_count;

  assign fifo_pop = (tx_state == TX_IDLE) && !fifo_empty;

  cl_uart_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (s_axi_aclk),
    .reset (s_axi_areset),
    .push  (tx_start),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer: line level is registered together with the state it belongs to.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      cl_sertc    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      tx_busy <= (fifo_count != '0) || (tx_state != TX_IDLE);
      if (tx_start && fifo_full && !fifo_pop) tx_overflow <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_shift <= fifo_dout;
            tx_cnt   <= '0;
            cl_sertc <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            cl_sertc <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              cl_sertc <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              cl_sertc <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic [1:0]        rx_sync;
  logic              rx_line;
  cl_uart_rx_state_t rx_state;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;

  // SerTFG is asynchronous; preset high so reset does not look like a start bit.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) rx_sync <= 2'b11;
    else              rx_sync <= {rx_sync[0], cl_sertfg};
  end

  assign rx_line = rx_sync[1];

  // Deserializer: start bit re-checked at mid-bit, then one sample per bit period.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_line) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_line, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_line) begin
              rx_data  <= rx_shift;
              rx_ready <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_BREAK;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_line) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cameralink_uart_phy.sv
// Scoreboard bench for cameralink_uart_phy: queue/timer TX model, frame-level RX model, line monitors.
module tb_cameralink_uart_phy;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       s_axi_areset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_overflow;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       cl_sertc;
  logic       cl_sertfg;

  always #5 clk = ~clk;

  cameralink_uart_phy #(
    .CLK_FREQ_HZ   (1_600_000),
    .BAUD_RATE     (100_000),
    .TX_FIFO_DEPTH (DEPTH)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (s_axi_areset),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_overflow  (tx_overflow),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .cl_sertc     (cl_sertc),
    .cl_sertfg    (cl_sertfg)
  );

  typedef struct {
    bit         ferr;
    logic [7:0] data;
  } rx_ev_t;

  int          checks   = 0;
  int          failures = 0;
  rx_ev_t      rx_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  model_q[$];
  logic [7:0]  rx_last_good = 8'h00;
  bit          exp_ovf = 1'b0;
  longint      cyc = 0;
  longint      free_at = 0;
  int unsigned reset_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // TX reference: a byte queue of DEPTH slots feeding a line that is busy FRAME+1 cycles per byte.
  always @(posedge clk) begin
    if (s_axi_areset) begin
      model_q.delete();
      tx_exp_q.delete();
      free_at = 0;
      exp_ovf = 1'b0;
      reset_count++;
    end else begin
      if (cyc >= free_at && model_q.size() != 0) begin
        void'(model_q.pop_front());
        free_at = cyc + FRAME + 1;
      end
      if (tx_start) begin
        if (model_q.size() < DEPTH) begin
          model_q.push_back(tx_data);
          tx_exp_q.push_back(tx_data);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    cyc++;
  end

  // TX monitor: every frame must match its expected byte cycle for cycle.
  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (!s_axi_areset && cl_sertc === 1'b0) begin
        logic [7:0]  exp_b;
        logic [7:0]  got_b;
        logic        exp_bit;
        bit          have_exp;
        bit          timing_ok;
        bit          aborted;
        int unsigned start_rc;
        start_rc  = reset_count;
        have_exp  = tx_exp_q.size() != 0;
        exp_b     = have_exp ? tx_exp_q.pop_front() : 8'h00;
        got_b     = 8'h00;
        timing_ok = 1'b1;
        aborted   = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i != 0) @(negedge clk);
          if (reset_count != start_rc) begin
            aborted = 1'b1;
            break;
          end
          if (i < CPB)          exp_bit = 1'b0;
          else if (i < 9 * CPB) exp_bit = exp_b[3'((i - CPB) / CPB)];
          else                  exp_bit = 1'b1;
          if (cl_sertc !== exp_bit) timing_ok = 1'b0;
          if (i >= CPB && i < 9 * CPB && (i % CPB) == CPB / 2)
            got_b[3'((i - CPB) / CPB)] = cl_sertc;
        end
        if (!aborted) begin
          check("tx_frame_expected", 32'(have_exp), 1);
          check("tx_frame_data", 32'(got_b), 32'(exp_b));
          check("tx_frame_timing", 32'(timing_ok), 1);
        end
      end
    end
  end

  // RX monitor: every strobe must match the next expected frame outcome.
  initial begin : rx_monitor
    rx_ev_t ev;
    forever begin
      @(negedge clk);
      if (rx_ready === 1'b1 || rx_frame_err === 1'b1) begin
        if (rx_exp_q.size() == 0) begin
          check("rx_unexpected_strobe", 32'({rx_ready, rx_frame_err}), 0);
        end else begin
          ev = rx_exp_q.pop_front();
          check("rx_strobe_kind", 32'({rx_ready, rx_frame_err}), ev.ferr ? 1 : 2);
          check("rx_data", 32'(rx_data), 32'(ev.data));
        end
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input bit stop_ok, input int unsigned hold);
    rx_ev_t ev;
    if (stop_ok) rx_last_good = b;
    ev.ferr = !stop_ok;
    ev.data = rx_last_good;
    rx_exp_q.push_back(ev);
    cl_sertfg = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      cl_sertfg = b[i];
      cycles(CPB);
    end
    cl_sertfg = stop_ok;
    cycles(CPB);
    if (!stop_ok) cycles(hold);
    cl_sertfg = 1'b1;
    cycles(2);
  endtask

  task automatic glitch(input int unsigned len);
    cl_sertfg = 1'b0;
    cycles(len);
    cl_sertfg = 1'b1;
    cycles(CPB);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_start = 1'b1;
    tx_data  = b;
    cycles(1);
    tx_start = 1'b0;
  endtask

  task automatic apply_reset();
    s_axi_areset = 1'b1;
    cycles(1);
    s_axi_areset = 1'b0;
    rx_last_good = 8'h00;
  endtask

  task automatic wait_tx_drain(input string name);
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || model_q.size() != 0 || tx_busy) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 8000), 1);
    cycles(1);
  endtask

  initial begin
    s_axi_areset = 1'b1;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    cl_sertfg    = 1'b1;
    cycles(3);
    s_axi_areset = 1'b0;

    @(negedge clk);
    check("rst_sertc", 32'(cl_sertc), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_overflow", 32'(tx_overflow), 0);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(rx_frame_err), 0);
    cycles(1);

    // Single byte on an idle block: start bit two edges after the strobe is driven.
    push_byte(8'hA5);
    @(negedge clk);
    check("t1_line_at_push", 32'(cl_sertc), 1);
    @(posedge clk);
    @(negedge clk);
    check("t1_start_bit", 32'(cl_sertc), 0);
    repeat (FRAME) @(posedge clk);
    @(negedge clk);
    check("t1_busy_after_stop", 32'(tx_busy), 1);
    @(posedge clk);
    @(negedge clk);
    check("t1_busy_released", 32'(tx_busy), 0);
    cycles(1);

    // Burst of 17 while a frame is already on the line: the 17th finds the FIFO full.
    push_byte(8'hC3);
    cycles(20);
    for (int k = 0; k < 17; k++) begin
      tx_start = 1'b1;
      tx_data  = 8'(k);
      cycles(1);
    end
    tx_start = 1'b0;
    @(negedge clk);
    check("t2_overflow", 32'(tx_overflow), 1);
    cycles(1);
    // Keep pushing while full so pops coincide with pushes.
    for (int k = 0; k < 200; k++) begin
      tx_start = 1'b1;
      tx_data  = 8'h80 | 8'(k);
      cycles(1);
    end
    tx_start = 1'b0;
    wait_tx_drain("t2_drain");
    check("t2_overflow_model", 32'(tx_overflow), 32'(exp_ovf));

    // RX: good frame, stop-bit error with a long break, glitch then good frame.
    send_rx(8'h3C, 1'b1, 0);
    cycles(10);
    send_rx(8'h55, 1'b0, 40);
    cycles(5);
    check("t4_rx_data_held", 32'(rx_data), 'h3C);
    glitch(4);
    send_rx(8'h81, 1'b1, 0);
    cycles(10);
    check("t5_rx_data", 32'(rx_data), 'h81);

    // Randomised full-duplex traffic from a clean reset.
    apply_reset();
    fork
      begin
        for (int k = 0; k < 2500; k++) begin
          tx_start = ($urandom_range(0, 29) == 0);
          tx_data  = 8'($urandom);
          cycles(1);
        end
        tx_start = 1'b0;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          if ($urandom_range(0, 2) == 0) glitch($urandom_range(1, 5));
          send_rx(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 30));
          cycles($urandom_range(1, 30));
        end
      end
    join
    wait_tx_drain("rand_drain");
    check("rand_overflow", 32'(tx_overflow), 32'(exp_ovf));

    // Reset in the middle of a data bit with a second byte still queued.
    push_byte(8'hFF);
    push_byte(8'h12);
    cycles(50);
    s_axi_areset = 1'b1;
    cycles(1);
    s_axi_areset = 1'b0;
    @(negedge clk);
    check("t6_sertc_high", 32'(cl_sertc), 1);
    check("t6_busy_low", 32'(tx_busy), 0);
    cycles(10);
    check("t6_fifo_empty_busy", 32'(tx_busy), 0);
    check("t6_fifo_empty_line", 32'(cl_sertc), 1);
    check("t6_overflow_cleared", 32'(tx_overflow), 0);

    cycles(20);
    check("rx_pending_events", 32'(rx_exp_q.size()), 0);
    check("tx_pending_frames", 32'(tx_exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
